// File: rtl/nmr_vote_controller.sv
// N-modular-redundancy voter and fault-management controller.
// Votes a packed bundle {PC, ALUResult, RD2, MemWrite} from NCH replicated
// cores. Each channel that keeps disagreeing is masked out. The block runs a
// hold/resync handshake with the recovery logic, and it enters a sticky FAIL
// state when no majority exists.
//
// Ports:
//   clk, rst_in    clock; asynchronous active-high reset
//   ch_data        NCH bundles, channel i at [i*W +: W]
//   clr_mask       pulse: clear fault mask and consecutive-mismatch counters
//   recov_done     pulse: recovery logic finished resyncing the cores
//   voted_data     registered majority bundle
//   vote_valid     voted_data came from a vote on the last edge
//   mismatch_vec   active channels that disagreed on the last vote
//   fault_mask     channels excluded from voting
//   err_cnt        saturating count of vote cycles with any mismatch
//   state          NORMAL=0, DEGRADED=1, RECOVER=2, FAIL=3
//   core_hold      hold the cores (RECOVER or FAIL)
//   recov_req      resync request (RECOVER)
//   fail           sticky failure (FAIL)
module nmr_vote_controller #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned W        = 97,
  parameter int unsigned FAULT_TH = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [NCH*W-1:0] ch_data,
  input  logic             clr_mask,
  input  logic             recov_done,
  output logic [W-1:0]     voted_data,
  output logic             vote_valid,
  output logic [NCH-1:0]   mismatch_vec,
  output logic [NCH-1:0]   fault_mask,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state,
  output logic             core_hold,
  output logic             recov_req,
  output logic             fail
);

  // Width of a channel count. It holds values up to 7.
  localparam int unsigned IDX_W  = 3;
  // Width of 2*count, used in the majority test.
  localparam int unsigned SUM_W  = IDX_W + 1;
  // Width of a consecutive-mismatch counter. It holds FAULT_TH values up to 15.
  localparam int unsigned CONS_W = 4;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_RECOVER  = 2'd2,
    ST_FAIL     = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [NCH-1:0][CONS_W-1:0]    consec_q, consec_d;

  logic [W-1:0]                  voted_d;
  logic                          valid_d;
  logic [NCH-1:0]                mism_d;
  logic [NCH-1:0]                mask_d;
  logic [CNT_W-1:0]              err_d;

  logic [W-1:0]                  ch_c [NCH];
  logic [IDX_W-1:0]              act_cnt_c;
  logic [IDX_W-1:0]              agree_c;
  logic                          maj_ok_c;
  logic [W-1:0]                  maj_data_c;
  logic [NCH-1:0]                diff_c;
  logic [CNT_W-1:0]              err_inc_c;

  // Unpack the channel bundles.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      ch_c[i] = ch_data[i*W +: W];
    end
  end

  // Count the active (unmasked) channels.
  always_comb begin
    act_cnt_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!fault_mask[i]) act_cnt_c = act_cnt_c + IDX_W'(1);
    end
  end

  // Word-level majority vote. The loop runs from high index to low, so the
  // last assignment, and therefore the lowest-index winner, supplies the data.
  always_comb begin
    maj_ok_c   = 1'b0;
    maj_data_c = '0;
    agree_c    = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      agree_c = '0;
      for (int j = 0; j < int'(NCH); j++) begin
        if (!fault_mask[j] && (ch_c[j] == ch_c[i])) agree_c = agree_c + IDX_W'(1);
      end
      if (!fault_mask[i] && ({agree_c, 1'b0} > SUM_W'(act_cnt_c))) begin
        maj_ok_c   = 1'b1;
        maj_data_c = ch_c[i];
      end
    end
  end

  // Active channels that disagree with the majority.
  always_comb begin
    diff_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      diff_c[i] = !fault_mask[i] && (ch_c[i] != maj_data_c);
    end
  end

  assign err_inc_c = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);

  // Next-state and datapath update. Every register holds unless a case
  // below overrides it.
  always_comb begin
    state_d  = state_q;
    voted_d  = voted_data;
    valid_d  = 1'b0;
    mism_d   = mismatch_vec;
    mask_d   = fault_mask;
    consec_d = consec_q;
    err_d    = err_cnt;

    unique case (state_q)
      ST_NORMAL, ST_DEGRADED: begin
        if (clr_mask) begin
          // A clear takes priority over any vote in the same cycle.
          mask_d   = '0;
          consec_d = '0;
          mism_d   = '0;
          state_d  = ST_NORMAL;
        end else if (!maj_ok_c) begin
          state_d = ST_FAIL;
          mism_d  = ~fault_mask;
          err_d   = err_inc_c;
        end else begin
          voted_d = maj_data_c;
          valid_d = 1'b1;
          mism_d  = diff_c;
          for (int i = 0; i < int'(NCH); i++) begin
            if (diff_c[i]) begin
              if (consec_q[i] < CONS_W'(FAULT_TH)) consec_d[i] = consec_q[i] + CONS_W'(1);
              if (consec_d[i] == CONS_W'(FAULT_TH)) mask_d[i] = 1'b1;
            end else if (!fault_mask[i]) begin
              consec_d[i] = '0;
            end
          end
          if (|diff_c) begin
            err_d   = err_inc_c;
            state_d = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        if (recov_done) state_d = (fault_mask == '0) ? ST_NORMAL : ST_DEGRADED;
      end
      ST_FAIL: begin
        if (clr_mask) begin
          mask_d   = '0;
          consec_d = '0;
          state_d  = ST_RECOVER;
        end
      end
    endcase
  end

  // State and datapath registers. The handshake outputs are decoded from the
  // next state, so they change together with the state register.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_NORMAL;
      consec_q     <= '0;
      voted_data   <= '0;
      vote_valid   <= 1'b0;
      mismatch_vec <= '0;
      fault_mask   <= '0;
      err_cnt      <= '0;
      core_hold    <= 1'b0;
      recov_req    <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      consec_q     <= consec_d;
      voted_data   <= voted_d;
      vote_valid   <= valid_d;
      mismatch_vec <= mism_d;
      fault_mask   <= mask_d;
      err_cnt      <= err_d;
      core_hold    <= (state_d == ST_RECOVER) || (state_d == ST_FAIL);
      recov_req    <= (state_d == ST_RECOVER);
      fail         <= (state_d == ST_FAIL);
    end
  end

  assign state = state_q;

endmodule

// File: doc/nmr_vote_controller.md
# nmr_vote_controller

Parametrised N-modular-redundancy voter and fault-management controller that sits between the replicated `Main_core` instances and the shared PC controller, data memory and recovery register. It generalises the fixed triple voter in several ways:

- It votes on an arbitrary-width packed core output bundle from `NCH` channels.
- It tracks per-channel consecutive mismatches and permanently masks a channel that keeps disagreeing.
- It sequences a hold/resync handshake with the recovery logic.
- It escalates to a sticky failure state when no majority exists.

## Interface
Parameters:
- `NCH`, 3: number of redundant channels; legal range 2..7.
- `W`, 97: bits per channel bundle, packed as `{PC[31:0], ALUResult[31:0], RD2[31:0], MemWrite}`.
- `FAULT_TH`, 4: consecutive mismatching votes after which a channel is masked; legal range 1..15.
- `CNT_W`, 8: width of the saturating mismatch-event counter.

Ports:
- `clk`  in  1  the one clock; all state updates on the rising edge.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `ch_data`  in  `NCH*W`  channel bundles; channel i occupies `[i*W +: W]`.
- `clr_mask`  in  1  single-cycle pulse: clear fault mask and consecutive-mismatch counters.
- `recov_done`  in  1  single-cycle pulse from recovery logic: core resync complete.
- `voted_data`  out  `W`  registered majority bundle.
- `vote_valid`  out  1  `voted_data` was produced by a vote this cycle.
- `mismatch_vec`  out  `NCH`  registered: active channels that disagreed with the majority on the last vote.
- `fault_mask`  out  `NCH`  masked (excluded) channels.
- `err_cnt`  out  `CNT_W`  saturating count of vote cycles with at least one mismatch.
- `state`  out  2  NORMAL=0, DEGRADED=1, RECOVER=2, FAIL=3.
- `core_hold`  out  1  hold cores; high in RECOVER and FAIL.
- `recov_req`  out  1  resync request; high in RECOVER.
- `fail`  out  1  high in FAIL.

## Operation
- **Active set:** the active channels are those with `~fault_mask`, and `A` is the number of active channels.
- **Word-level vote, evaluated combinationally each cycle:**
  - For each active channel i, count the active channels j (including i) whose bundle equals channel i's.
  - Channel i is a winner if `2*count > A`. The lowest-index winner supplies the majority.
  - If there is no winner, no majority exists.
- **Vote cycle:** any cycle in NORMAL or DEGRADED without `clr_mask`. On a vote cycle with a majority:
  - `voted_data` ← majority; `vote_valid` ← 1.
  - `mismatch_vec` bit i ← 1 for each active channel differing from the majority.
  - For each mismatching channel: `consec[i]`++, saturating at `FAULT_TH`. When it reaches `FAULT_TH`, `fault_mask[i]` ← 1.
  - For each agreeing channel: `consec[i]` ← 0.
  - If any mismatch: `err_cnt`++ (saturating at all-ones) and state → RECOVER. Otherwise state is unchanged.
- **Vote cycle with no majority:** state → FAIL; `vote_valid` ← 0; `voted_data` holds; `mismatch_vec` ← all active bits; `err_cnt`++.
- **Transitions:**
  - RECOVER: `voted_data`, counters and mask are frozen, and `vote_valid` = 0. On `recov_done`: → NORMAL if `fault_mask` == 0, else → DEGRADED. `clr_mask` is ignored.
  - FAIL: sticky; outputs are frozen. `clr_mask` clears the mask and counters and moves the state to RECOVER. `recov_done` is ignored.
  - `clr_mask` in NORMAL or DEGRADED: mask, `consec` and `mismatch_vec` are cleared; state → NORMAL; no vote that cycle (`vote_valid` = 0). `clr_mask` has priority over a simultaneous mismatch. `err_cnt` is not cleared.
- **Two active channels:** a mismatch has no majority and therefore leads to FAIL (duplex compare behaviour).
- **All channels but one masked:** `A` = 1, and that single channel always wins.
- **Internal consistency (design invariant):** `A` is never 0, because a channel is masked only while a majority of the other active channels exists.

## Timing
- **Reset (asynchronous):** all outputs are 0, state = NORMAL, `consec` = 0, and they stay so while `rst_in` is high. Reset takes effect immediately, with no clock edge needed, including in the middle of RECOVER or FAIL.
- **Latency:** `ch_data` is sampled on edge k; `voted_data`, `vote_valid`, `mismatch_vec`, `err_cnt` and `fault_mask` update on edge k.
- **Mismatch handshake:** after a mismatch sampled at edge k, `state`, `core_hold` and `recov_req` are valid after edge k. This gives a 1-cycle reaction.
- **Recovery handshake:** `recov_req` stays high until `recov_done` is sampled; the state leaves RECOVER on that edge. `recov_done` is a pulse; holding it high has no further effect.
- **Output encoding:** `core_hold`, `recov_req` and `fail` are decoded from registered state, so they are glitch-free.

## Test plan
- **Clean vote:**
  - Stimulus: `NCH`=3; reset released; all channels = `0x0_0000_0040_0000_0010_0000_0000_1`.
  - Required response: next edge `vote_valid`=1, `voted_data` = that value, `state`=0, `err_cnt`=0.
- **Transient fault:**
  - Stimulus: channel 1 differs for one cycle.
  - Required response:
    - After that edge: `mismatch_vec`=3'b010, `err_cnt`=1, `state`=2, `core_hold`=`recov_req`=1.
    - After `recov_done` pulse: `state`=0 next edge and `consec[1]` cleared on the following agreeing vote.
- **Permanent fault:**
  - Stimulus: channel 2 mismatches on 4 consecutive vote cycles, with `recov_done` after each.
  - Required response:
    - After the 4th mismatch: `fault_mask`=3'b100; after `recov_done`: `state`=1.
    - Further channel 2 garbage: `mismatch_vec`=0, `err_cnt` stays 4.
- **Degraded escalation:**
  - Stimulus: in DEGRADED (mask 3'b100), channel 0 ≠ channel 1.
  - Required response: `state`=3, `fail`=1, `core_hold`=1. Then `clr_mask` → `state`=2, `fault_mask`=0.
- **Total disagreement:**
  - Stimulus: in NORMAL, all three channels distinct.
  - Required response: `state`=3 directly, `vote_valid`=0, `voted_data` unchanged.
- **Reset and saturation:**
  - Assert `rst_in` between edges during RECOVER: all outputs 0 before the next edge.
  - With `CNT_W`=2: 5 mismatch events give `err_cnt`=3.
